fifo_stream_drain: RTL and testbench



---
 rtl/fifo_stream_drain_pkg.sv | 13 +
 rtl/fifo_stream_drain_if.sv | 24 ++
 rtl/fifo_stream_drain_buf.sv | 55 +++++
 rtl/fifo_stream_drain.sv | 63 ++++++
 tb/tb_fifo_stream_drain.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_drain_pkg.sv
// Shared constants, types and pointer helper for the FIFO stream drain.
package fifo_drain_pkg;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_BUF_DEPTH = 3;

   typedef logic [$clog2(DEF_BUF_DEPTH+1)-1:0] cnt_t;
   typedef logic [$clog2(DEF_BUF_DEPTH)-1:0]   ptr_t;

   // Circular pointer advance; depth need not be a power of two.
   function automatic int unsigned next_ptr(input int unsigned p, input int unsigned depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/fifo_stream_drain_if.sv
// FIFO read port plus valid/ready stream; master is the drain side.
interface fifo_stream_drain_if
   import fifo_drain_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] fifo_rdata_i;
   logic             fifo_empty_i;
   logic             fifo_error_i;
   logic             fifo_rd_en_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_valid_o;
   logic             m_ready_i;

   modport master (
      input  fifo_rdata_i, fifo_empty_i, fifo_error_i, m_ready_i,
      output fifo_rd_en_o, m_data_o, m_valid_o
   );

   modport slave (
      output fifo_rdata_i, fifo_empty_i, fifo_error_i, m_ready_i,
      input  fifo_rd_en_o, m_data_o, m_valid_o
   );
endinterface

// File: rtl/fifo_stream_drain_buf.sv
// Circular output buffer holding words returned by the FIFO until the consumer takes them.
module drain_buf
   import fifo_drain_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   input  logic                           clear,
   output logic [WIDTH-1:0]               head_data,
   output logic [$clog2(BUF_DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(BUF_DEPTH+1);
   localparam int PW = $clog2(BUF_DEPTH);

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]    hd_q, tl_q;
   logic [CW-1:0]    cnt_q;

   assign head_data = mem[hd_q];
   assign count     = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         // storage keeps stale words; count=0 keeps them invisible
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem[tl_q] <= push_data;
            tl_q      <= PW'(next_ptr(32'(tl_q), BUF_DEPTH));
         end
         if (pop) hd_q <= PW'(next_ptr(32'(hd_q), BUF_DEPTH));
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always @(posedge clk) begin
      if (rst_n && !clear && push) assert (cnt_q != CW'(BUF_DEPTH));
   end
endmodule

// File: rtl/fifo_stream_drain.sv
// FIFO-to-stream drain: read issue, latency absorption, sticky error.
// Optional delivered-word counter under FIFO_STREAM_DRAIN_CNT_EN.
module fifo_stream_drain
   import fifo_drain_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   output logic                 err_o,
   fifo_stream_drain_if.master  bus
`ifdef FIFO_STREAM_DRAIN_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] word_cnt_o
`endif
);
   localparam int CW = $clog2(BUF_DEPTH+1);

   logic [CW-1:0] count;
   logic          inflight_q;
   logic          push, pop;

   // Reserve room for the in-flight word so a read is never issued without space;
   // m_ready_i deliberately has no path here.
   assign bus.fifo_rd_en_o = rst_i && !bus.fifo_empty_i && !flush_i &&
                             ((int'(count) + int'(inflight_q)) < BUF_DEPTH);
   assign bus.m_valid_o    = (count != '0) && !flush_i;
   assign push             = inflight_q && !flush_i;
   assign pop              = bus.m_valid_o && bus.m_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) inflight_q <= 1'b0;
      else        inflight_q <= bus.fifo_rd_en_o;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                err_o <= 1'b0;
      else if (flush_i)          err_o <= 1'b0;
      else if (bus.fifo_error_i) err_o <= 1'b1;
   end

   drain_buf #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .push      (push),
      .push_data (bus.fifo_rdata_i),
      .pop       (pop),
      .clear     (flush_i),
      .head_data (bus.m_data_o),
      .count     (count)
   );

`ifdef FIFO_STREAM_DRAIN_CNT_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                        word_cnt_o <= '0;
      else if (flush_i)                  word_cnt_o <= '0;
      else if (pop && (~word_cnt_o != '0)) word_cnt_o <= word_cnt_o + 1'b1;
   end
`endif
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_drain;
   import fifo_drain_pkg::*;

   localparam int WIDTH     = 8;
   localparam int BUF_DEPTH = 3;
   localparam int CNT_WIDTH = 16;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic flush_i = 1'b0;
   logic err_o;
`ifdef FIFO_STREAM_DRAIN_CNT_EN
   logic [CNT_WIDTH-1:0] word_cnt_o;
`endif

   fifo_stream_drain_if #(.WIDTH(WIDTH)) bus ();

   fifo_stream_drain #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .err_o      (err_o),
      .bus        (bus)
`ifdef FIFO_STREAM_DRAIN_CNT_EN
      ,
      .word_cnt_o (word_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   logic [7:0] mem [64];
   int         wp = 0;
   int         rp;
   logic       stall = 1'b0;

   assign bus.fifo_empty_i = (wp == rp) || stall;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rp               <= 0;
         bus.fifo_rdata_i <= '0;
      end else if (bus.fifo_rd_en_o) begin
         bus.fifo_rdata_i <= mem[rp];
         rp               <= rp + 1;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic restart();
      rst_i            = 1'b0;
      flush_i          = 1'b0;
      stall            = 1'b0;
      bus.m_ready_i    = 1'b0;
      bus.fifo_error_i = 1'b0;
      wp               = 0;
      #1;
   endtask

   task automatic load(input logic [7:0] w);
      mem[wp] = w;
      wp++;
   endtask

   task automatic release_rst();
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
   endtask

   int e_rd [6] = '{1, 1, 1, 0, 0, 0};
   int e_v  [6] = '{0, 0, 1, 1, 1, 0};
   int e_d  [6] = '{0, 0, 8'h11, 8'h22, 8'h33, 0};

   initial begin
      int got, first, last, reads;

      // basic three-word drain, latency and rd_en shape
      restart();
      load(8'h11); load(8'h22); load(8'h33);
      bus.m_ready_i = 1'b1;
      #1;
      chk("rst_rd_en", bus.fifo_rd_en_o, 0);
      chk("rst_valid", bus.m_valid_o, 0);
      chk("rst_data",  bus.m_data_o, 0);
      chk("rst_err",   err_o, 0);
      release_rst();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) step();
         chk($sformatf("t1_rd_c%0d", c), bus.fifo_rd_en_o, e_rd[c]);
         chk($sformatf("t1_valid_c%0d", c), bus.m_valid_o, e_v[c]);
         if (e_v[c] != 0) chk($sformatf("t1_data_c%0d", c), bus.m_data_o, e_d[c]);
      end

      // backpressure: only BUF_DEPTH reads, head held, then full-rate drain
      restart();
      for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
      release_rst();
      reads = 0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) step();
         reads += int'(bus.fifo_rd_en_o);
      end
      chk("t2_reads", reads, 3);
      chk("t2_hold_valid", bus.m_valid_o, 1);
      chk("t2_hold_data", bus.m_data_o, 8'hA0);
      bus.m_ready_i = 1'b1;
      #1;
      got = 0; first = -1; last = -1;
      for (int c = 0; c < 30 && got < 8; c++) begin
         if (c > 0) step();
         if (bus.m_valid_o) begin
            chk($sformatf("t2_word%0d", got), bus.m_data_o, 8'hA0 + got);
            if (got == 0) first = c;
            last = c;
            got++;
         end
      end
      chk("t2_count", got, 8);
      chk("t2_rate", last - first, 7);

      // FIFO empty toggling every other cycle
      restart();
      for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
      bus.m_ready_i = 1'b1;
      release_rst();
      got = 0;
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (c > 0) step();
         stall = (c % 2) == 1;
         #1;
         chk($sformatf("t3_rd_empty_c%0d", c), bus.fifo_rd_en_o & bus.fifo_empty_i, 0);
         if (bus.m_valid_o) begin
            chk($sformatf("t3_word%0d", got), bus.m_data_o, 8'h30 + got);
            got++;
         end
      end
      stall = 1'b0;
      chk("t3_count", got, 8);
      for (int c = 0; c < 4; c++) step();
      chk("t3_no_extra", bus.m_valid_o, 0);

      // flush with two buffered words and one in flight
      restart();
      load(8'h41); load(8'h42); load(8'h43);
      release_rst();
      step();
      step();
      chk("t4_pre_valid", bus.m_valid_o, 1);
      chk("t4_pre_data", bus.m_data_o, 8'h41);
      step();
      flush_i = 1'b1;
      #1;
      chk("t4_flush_valid", bus.m_valid_o, 0);
      chk("t4_flush_rd", bus.fifo_rd_en_o, 0);
      step();
      flush_i = 1'b0;
      #1;
      chk("t4_after_valid", bus.m_valid_o, 0);
      chk("t4_after_rd", bus.fifo_rd_en_o, 0);
      bus.m_ready_i = 1'b1;
      step();
      load(8'h5A);
      #1;
      chk("t4_new_rd", bus.fifo_rd_en_o, 1);
      chk("t4_new_valid0", bus.m_valid_o, 0);
      step();
      chk("t4_new_valid1", bus.m_valid_o, 0);
      step();
      chk("t4_new_valid2", bus.m_valid_o, 1);
      chk("t4_new_data", bus.m_data_o, 8'h5A);

      // sticky error and flush clearing it
      step();
      bus.fifo_error_i = 1'b1;
      #1;
      chk("t5_err_same", err_o, 0);
      step();
      bus.fifo_error_i = 1'b0;
      #1;
      chk("t5_err_set", err_o, 1);
      step();
      chk("t5_err_hold", err_o, 1);
      step();
      flush_i = 1'b1;
      #1;
      chk("t5_err_flushcyc", err_o, 1);
      step();
      flush_i = 1'b0;
      #1;
      chk("t5_err_clr", err_o, 0);
      step();
      bus.fifo_error_i = 1'b1;
      flush_i = 1'b1;
      step();
      bus.fifo_error_i = 1'b0;
      flush_i = 1'b0;
      #1;
      chk("t5_flush_prio", err_o, 0);

      // asynchronous reset mid-stream, then counted handshakes
      for (int i = 0; i < 8; i++) load(8'h60 + 8'(i));
      bus.fifo_error_i = 1'b1;
      step();
      bus.fifo_error_i = 1'b0;
      for (int c = 0; c < 3; c++) step();
      chk("t6_pre_valid", bus.m_valid_o, 1);
      chk("t6_pre_err", err_o, 1);
      rst_i = 1'b0;
      #1;
      chk("t6_rst_rd", bus.fifo_rd_en_o, 0);
      chk("t6_rst_valid", bus.m_valid_o, 0);
      chk("t6_rst_data", bus.m_data_o, 0);
      chk("t6_rst_err", err_o, 0);
`ifdef FIFO_STREAM_DRAIN_CNT_EN
      chk("t6_rst_cnt", word_cnt_o, 0);
`endif
      restart();
      for (int i = 0; i < 5; i++) load(8'h71 + 8'(i));
      bus.m_ready_i = 1'b1;
      release_rst();
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         if (c > 0) step();
         if (bus.m_valid_o) begin
            chk($sformatf("t6_word%0d", got), bus.m_data_o, 8'h71 + got);
            got++;
         end
      end
      step();
      chk("t6_count", got, 5);
`ifdef FIFO_STREAM_DRAIN_CNT_EN
      chk("t6_word_cnt", word_cnt_o, 5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
